// File: rtl/ofm_in_fsm_pkg.sv
// ---------------------------------------------------------------------------
// ofm_in_fsm_pkg
// Definitions shared by the transmit-path writer (ofm_in_fsm) and the
// MAC-side reader: FSM state encodings, data FIFO word layout and the
// control-FIFO frame descriptor layout, plus a descriptor packing helper.
// ---------------------------------------------------------------------------
package ofm_in_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,  // waiting for the first beat of a frame
    S_DATA = 3'd1,  // frame in progress
    S_DROP = 3'd2,  // frame truncated, discarding remaining beats
    S_EOF  = 3'd3   // descriptor write
  } ofm_state_e;

  // Data FIFO word: {tlast, tkeep[7:0], tdata[63:0]}
  localparam int DATA_W    = 73;
  localparam int TLAST_BIT = 72;

  // Control FIFO descriptor
  localparam int DESC_W    = 34;
  localparam int LEN_LSB   = 0;
  localparam int LEN_MSB   = 15;
  localparam int BEATS_LSB = 16;
  localparam int BEATS_MSB = 27;
  localparam int TRUNC_BIT = 32;
  localparam int ERR_BIT   = 33;

  function automatic logic [DESC_W-1:0] pack_desc(
    input logic        err,
    input logic        trunc,
    input logic [11:0] beats,
    input logic [15:0] len
  );
    logic [DESC_W-1:0] d;
    d                      = '0;
    d[LEN_MSB:LEN_LSB]     = len;
    d[BEATS_MSB:BEATS_LSB] = beats;
    d[TRUNC_BIT]           = trunc;
    d[ERR_BIT]             = err;
    return d;
  endfunction

endpackage

// File: rtl/ofm_in_fsm_popcount8.sv
// ---------------------------------------------------------------------------
// ofm_in_fsm_popcount8
// Counts the set bits of an 8-bit byte-enable mask (bytes in a beat).
// Ports:
//   keep_i   in  8  byte enables
//   count_o  out 4  number of enabled bytes (0..8)
// ---------------------------------------------------------------------------
module ofm_in_fsm_popcount8 (
  input  logic [7:0] keep_i,
  output logic [3:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'b000, keep_i[i]};
    end
  end

endmodule

// File: rtl/ofm_in_fsm.sv
// ---------------------------------------------------------------------------
// ofm_in_fsm
// Write-side frame FSM of the transmit path. Copies MM2S AXI-Stream beats
// into the data FIFO and, once a frame ends, writes one length/status
// descriptor into the control FIFO. Frames longer than C_MAX_BEATS are
// truncated (terminating tlast forced, trunc flag set) and the tail dropped.
// Ports:
//   tx_clk, tx_reset                clock, synchronous active-high reset
//   s_axis_*                        MM2S stream input (tdata/tkeep/tvalid/
//                                   tlast/tuser in, tready out)
//   data_fifo_wdata/wren/full       73-bit data FIFO write port
//   ctrl_fifo_wdata/wren/full       34-bit descriptor FIFO write port
//   ofm_in_fsm_dbg                  {1'b0, state[2:0]}
// ---------------------------------------------------------------------------
module ofm_in_fsm
  import ofm_in_fsm_pkg::*;
#(
  parameter int C_MAX_BEATS = 1200
) (
  input  logic                tx_clk,
  input  logic                tx_reset,
  input  logic [63:0]         s_axis_tdata,
  input  logic [7:0]          s_axis_tkeep,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   data_fifo_wdata,
  output logic                data_fifo_wren,
  input  logic                data_fifo_full,
  output logic [DESC_W-1:0]   ctrl_fifo_wdata,
  output logic                ctrl_fifo_wren,
  input  logic                ctrl_fifo_full,
  output logic [3:0]          ofm_in_fsm_dbg
);

  localparam logic [11:0] MAX_M1 = 12'(C_MAX_BEATS - 1);

  ofm_state_e  state_q, state_d;
  logic [11:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        err_q, err_d;
  logic        trunc_flag_q, trunc_flag_d;
  // Holds tready low for the first cycle after reset is released.
  logic        init_q;

  logic [3:0]  keep_cnt;
  logic        accept;
  logic        trunc;

  ofm_in_fsm_popcount8 u_popcount (
    .keep_i  (s_axis_tkeep),
    .count_o (keep_cnt)
  );

  always_ff @(posedge tx_clk) begin
    if (tx_reset) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      err_q        <= 1'b0;
      trunc_flag_q <= 1'b0;
      init_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      err_q        <= err_d;
      trunc_flag_q <= trunc_flag_d;
      init_q       <= 1'b0;
    end
  end

  // tready depends only on state and FIFO status, never on tvalid.
  // In S_IDLE the control FIFO check reserves the descriptor slot for the
  // frame about to start, since nothing else writes that FIFO.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      S_IDLE:  s_axis_tready = ~data_fifo_full & ~ctrl_fifo_full;
      S_DATA:  s_axis_tready = ~data_fifo_full;
      S_DROP:  s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
    if (tx_reset || init_q) begin
      s_axis_tready = 1'b0;
    end
  end

  assign accept = s_axis_tvalid & s_axis_tready;
  // Last beat that still fits and is not a natural end: force tlast on it.
  assign trunc  = (beat_cnt_q == MAX_M1) & ~s_axis_tlast;

  assign ofm_in_fsm_dbg = {1'b0, state_q};

  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    byte_cnt_d      = byte_cnt_q;
    err_d           = err_q;
    trunc_flag_d    = trunc_flag_q;
    data_fifo_wren  = 1'b0;
    data_fifo_wdata = {s_axis_tlast | trunc, s_axis_tkeep, s_axis_tdata};
    ctrl_fifo_wren  = (state_q == S_EOF);
    ctrl_fifo_wdata = pack_desc(err_q, trunc_flag_q, beat_cnt_q, byte_cnt_q);

    // Error marker counts on every accepted beat, dropped ones included.
    if (accept && s_axis_tuser) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DATA: begin
        if (accept) begin
          data_fifo_wren = 1'b1;
          beat_cnt_d     = beat_cnt_q + 12'd1;
          byte_cnt_d     = byte_cnt_q + {12'd0, keep_cnt};
          if (trunc) begin
            trunc_flag_d = 1'b1;
          end
          if (s_axis_tlast) begin
            state_d = S_EOF;
          end else if (trunc) begin
            state_d = S_DROP;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DROP: begin
        if (accept && s_axis_tlast) begin
          state_d = S_EOF;
        end
      end
      S_EOF: begin
        state_d      = S_IDLE;
        beat_cnt_d   = '0;
        byte_cnt_d   = '0;
        err_d        = 1'b0;
        trunc_flag_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
